// File: rtl/mem_responder.sv
// Single-port byte RAM behind a req/rdy handshake; response WAIT_STATES+1 cycles after acceptance.
// No queuing: req is ignored while busy, and rdata holds its last read value between reads.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module mem_responder #(
   parameter int DATA_WIDTH  = `REG_WIDTH,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdy,
   output logic                  err,
   output logic                  busy
);

   localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [3:0]        WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  rw_q, rw_d;
   logic                  oor_q, oor_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  go_resp;
   logic [IW-1:0]         sel_idx;
   logic                  sel_rw;
   logic                  sel_oor;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rw_d    = rw_q;
      oor_d   = oor_q;
      wdata_d = wdata_q;
      go_resp = 1'b0;
      sel_idx = idx_q;
      sel_rw  = rw_q;
      sel_oor = oor_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               // Range is decided once, at full address width, so high bits never alias into the RAM.
               idx_d   = addr[IW-1:0];
               rw_d    = rw;
               wdata_d = wdata;
               oor_d   = ({1'b0, addr} >= DEPTH_W);
               sel_idx = idx_d;
               sel_rw  = rw_d;
               sel_oor = oor_d;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WS_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      rdata_d = rdata_q;
      if (go_resp && sel_rw) begin
         rdata_d = sel_oor ? '0 : mem[sel_idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rw_q    <= 1'b0;
         oor_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         oor_q   <= oor_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM contents survive reset; an aborted request never reaches RESP, so it never writes.
   always_ff @(posedge clk) begin
      if (state_q == RESP && !rw_q && !oor_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign rdata = rdata_q;
   assign rdy   = (state_q == RESP);
   assign err   = (state_q == RESP) && oor_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut uses WAIT_STATES=2, dut0 uses WAIT_STATES=0; both DEPTH=256.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req, rw;
   logic [15:0] addr;
   logic [7:0]  wdata, rdata;
   logic        rdy, err, busy;
   logic        req0, rw0;
   logic [15:0] addr0;
   logic [7:0]  wdata0, rdata0;
   logic        rdy0, err0, busy0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .WAIT_STATES(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rdy(rdy), .err(err), .busy(busy));

   mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .req(req0), .rw(rw0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .rdy(rdy0), .err(err0), .busy(busy0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request on dut starting in the current cycle; returns the cycle offset of rdy (-1 on timeout).
   task automatic op(input logic is_rd, input logic [15:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic e, output int lat);
      req = 1'b1; rw = is_rd; addr = a; wdata = d;
      lat = -1; rd = '0; e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         req = 1'b0;
         if (rdy === 1'b1) begin
            lat = i; rd = rdata; e = err;
            break;
         end
      end
      if (lat >= 0) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req = 0; rw = 0; addr = '0; wdata = '0;
      req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
      tick(); tick();
      checks++; if (rdy !== 1'b0)    begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
      checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
      checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0 || rdata0 !== 8'h00)
         begin failures++; $display("FAIL reset_dut0 got busy=%b rdy=%b rdata=%h exp 0/0/00", busy0, rdy0, rdata0); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_write();
      logic [7:0] rd; logic e; int lat;
      req = 1; rw = 0; addr = 16'h0010; wdata = 8'h5A;
      tick();
      req = 0; rw = 1; addr = 16'h0020; wdata = 8'hFF;
      checks++; if (busy !== 1'b1 || rdy !== 1'b0) begin failures++; $display("FAIL wr_c1 got busy=%b rdy=%b exp 1/0", busy, rdy); end
      tick();
      checks++; if (busy !== 1'b1 || rdy !== 1'b0) begin failures++; $display("FAIL wr_c2 got busy=%b rdy=%b exp 1/0", busy, rdy); end
      tick();
      checks++; if (busy !== 1'b1 || rdy !== 1'b1 || err !== 1'b0)
         begin failures++; $display("FAIL wr_c3 got busy=%b rdy=%b err=%b exp 1/1/0", busy, rdy, err); end
      tick();
      checks++; if (busy !== 1'b0 || rdy !== 1'b0) begin failures++; $display("FAIL wr_c4 got busy=%b rdy=%b exp 0/0", busy, rdy); end
      op(1'b1, 16'h0010, 8'h00, rd, e, lat);
      checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL wr_latched_inputs got=%h exp=5a", rd); end
   endtask

   task automatic test_readback();
      logic [7:0] rd; logic e; int lat;
      op(1'b1, 16'h0010, 8'h00, rd, e, lat);
      checks++; if (lat !== 3)     begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      checks++; if (rd !== 8'h5A)  begin failures++; $display("FAIL rd_data got=%h exp=5a", rd); end
      checks++; if (e !== 1'b0)    begin failures++; $display("FAIL rd_err got=%b exp=0", e); end
      repeat (10) tick();
      checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL rd_hold_idle got=%h exp=5a", rdata); end
      op(1'b0, 16'h0030, 8'hC3, rd, e, lat);
      checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL rd_hold_write got=%h exp=5a", rdata); end
   endtask

   task automatic test_out_of_range();
      logic [7:0] rd; logic e; int lat;
      op(1'b0, 16'h0000, 8'h3C, rd, e, lat);
      checks++; if (e !== 1'b0 || lat !== 3) begin failures++; $display("FAIL oor_prewrite got err=%b lat=%0d exp 0/3", e, lat); end
      op(1'b1, 16'h0100, 8'h00, rd, e, lat);
      checks++; if (lat !== 3 || e !== 1'b1 || rd !== 8'h00)
         begin failures++; $display("FAIL oor_read got lat=%0d err=%b rdata=%h exp 3/1/00", lat, e, rd); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err_idle got=%b exp=0", err); end
      op(1'b0, 16'h0100, 8'h77, rd, e, lat);
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_write_err got=%b exp=1", e); end
      op(1'b1, 16'h0000, 8'h00, rd, e, lat);
      checks++; if (rd !== 8'h3C || e !== 1'b0) begin failures++; $display("FAIL oor_no_alias got=%h err=%b exp 3c/0", rd, e); end
      op(1'b1, 16'hFFFF, 8'h00, rd, e, lat);
      checks++; if (e !== 1'b1 || rd !== 8'h00) begin failures++; $display("FAIL oor_top got err=%b rdata=%h exp 1/00", e, rd); end
   endtask

   task automatic test_busy();
      logic [7:0] rd; logic e; int lat; int n;
      op(1'b0, 16'h0020, 8'h11, rd, e, lat);
      n = 0;
      req = 1; rw = 0; addr = 16'h0010; wdata = 8'h5A;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c <= 2) begin req = 1; rw = 0; addr = 16'h0020; wdata = 8'hEE; end
         else req = 0;
         if (rdy === 1'b1) n++;
      end
      checks++; if (n !== 1) begin failures++; $display("FAIL busy_one_rdy got=%0d exp=1", n); end
      op(1'b1, 16'h0020, 8'h00, rd, e, lat);
      checks++; if (rd !== 8'h11) begin failures++; $display("FAIL busy_ram20 got=%h exp=11", rd); end
      op(1'b1, 16'h0010, 8'h00, rd, e, lat);
      checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL busy_ram10 got=%h exp=5a", rd); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd; logic e; int lat;
      req = 1; rw = 0; addr = 16'h0010; wdata = 8'hA5;
      tick();
      req = 0;
      tick();
      reset_n = 1'b0;
      #1;
      checks++; if (rdy !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00)
         begin failures++; $display("FAIL mid_reset_outs got rdy=%b err=%b busy=%b rdata=%h exp 0/0/0/00", rdy, err, busy, rdata); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL mid_reset_no_rdy got=%b exp=0", rdy); end
      op(1'b1, 16'h0010, 8'h00, rd, e, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL mid_reset_first_edge got lat=%0d exp=3", lat); end
      checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL mid_reset_abort got=%h exp=5a", rd); end
   endtask

   task automatic test_zero_wait();
      req0 = 1; rw0 = 0; addr0 = 16'h0005; wdata0 = 8'h99;
      tick();
      req0 = 0;
      checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL zw_write_rdy got=%b exp=1", rdy0); end
      tick();
      req0 = 1; rw0 = 0; addr0 = 16'h0006; wdata0 = 8'h66;
      tick();
      req0 = 0;
      tick();
      req0 = 1; rw0 = 1; addr0 = 16'h0005;
      tick();
      req0 = 0;
      checks++; if (rdy0 !== 1'b1 || rdata0 !== 8'h99 || busy0 !== 1'b1)
         begin failures++; $display("FAIL zw_read1 got rdy=%b rdata=%h busy=%b exp 1/99/1", rdy0, rdata0, busy0); end
      tick();
      checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL zw_gap got rdy=%b busy=%b exp 0/0", rdy0, busy0); end
      req0 = 1; rw0 = 1; addr0 = 16'h0006;
      tick();
      req0 = 0;
      checks++; if (rdy0 !== 1'b1 || rdata0 !== 8'h66 || err0 !== 1'b0)
         begin failures++; $display("FAIL zw_read2 got rdy=%b rdata=%h err=%b exp 1/66/0", rdy0, rdata0, err0); end
      tick();
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL zw_end got=%b exp=0", rdy0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_out_of_range();
      test_busy();
      test_reset_mid();
      test_zero_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
